alu_issue_ctrl: RTL
===================

# alu_issue_ctrl

Issue-side controller for the 32-bit combinational ALU: accepts operation requests over a valid/ready handshake, decodes the 2-bit ALUOp plus 6-bit funct into the ALU's 4-bit select, drives and holds the ALU operands, and captures the result and zero flag into a response register. The controller sits between the decode stage and the ALU. It turns the ALU's untimed combinational interface into a registered, back-pressured request/response channel for the multi-cycle datapath.

## Interface
- `TAG_W`, 4: width of request/response tag, 1..8
- `SETTLE`, 1: cycles ALU inputs are held before capture, 1..15 (raise for MUL timing)

- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `req_valid`  in  1  request present
- `req_ready`  out  1  controller accepts request this cycle
- `req_aluop`  in  2  00 add, 01 sub, 10 use funct, 11 unsupported
- `req_funct`  in  6  R-type funct, used only when `req_aluop`=10
- `req_a`, `req_b`  in  32  operands
- `req_tag`  in  TAG_W  returned unchanged with response
- `alu_op1`, `alu_op2`  out  32  registered ALU operands
- `alu_sel`  out  4  registered ALU select
- `alu_out`  in  32  ALU result
- `alu_zf`  in  1  ALU zero flag
- `rsp_valid`  out  1  response present
- `rsp_ready`  in  1  consumer takes response
- `rsp_data`  out  32  captured result
- `rsp_zero`  out  1  captured zero flag
- `rsp_err`  out  1  unsupported operation
- `rsp_tag`  out  TAG_W  tag of the request
- `busy`  out  1  state != IDLE

## Operation
- Decode: aluop 00 -> 0010 (ADD); 01 -> 0110 (SUB). For aluop 10, funct 0x20 -> 0010, 0x22 -> 0110, 0x24 -> 0000 (AND), 0x25 -> 0001 (OR), 0x2A -> 0111 (SLT), 0x18 -> 0101 (MUL). Any other funct, and aluop 11, is unsupported.
- The controller never issues division. No other select codes are ever driven.
- FSM has three states.
  - IDLE: `req_ready`=1. On `req_valid`, a supported op registers `req_a`/`req_b`/sel/tag into `alu_*`, loads the counter with SETTLE-1 and goes to EXEC. An unsupported op leaves `alu_*` unchanged, loads `rsp_data`=0, `rsp_zero`=0, `rsp_err`=1 and the tag, and goes to RESP.
  - EXEC: `alu_*` held stable. The counter decrements each cycle. At the edge where the counter is 0, capture `alu_out`->`rsp_data`, `alu_zf`->`rsp_zero`, set `rsp_err`=0, and go to RESP.
  - RESP: `rsp_valid`=1. `rsp_*` are held stable until `rsp_ready`. On handshake, go to IDLE, unless the pipelining feature applies (see Configuration).
- `req_ready` is 0 in EXEC. In RESP it is 0 unless the pipelining feature is compiled in.
- `alu_*` holds its last value outside EXEC. The ALU output is only sampled in EXEC.
- `rsp_valid` must not drop without `rsp_ready`. `rsp_*` must not change while `rsp_valid`=1 and `rsp_ready`=0.

## Timing
- Reset values:
  - state IDLE
  - `req_ready`=1
  - `alu_op1`=0, `alu_op2`=0, `alu_sel`=0010
  - `rsp_valid`=0, `rsp_data`=0, `rsp_zero`=0, `rsp_err`=0, `rsp_tag`=0
  - `busy`=0
- Reset asserted mid-EXEC or mid-RESP: the in-flight operation is dropped and no response is produced.
- Supported op accepted at edge N: `rsp_valid`=1 after edge N+SETTLE.
- Unsupported op accepted at edge N: `rsp_valid`=1 after edge N.
- Without the pipelining feature, minimum request spacing is SETTLE+2 cycles. With it, minimum spacing is SETTLE+1.
- Sustained `rsp_ready`=0 stalls indefinitely, with no loss and no overwrite.

## Configuration
- `ALU_ISSUE_PIPE_EN` defined:
  - In RESP, `req_ready` = `rsp_ready`, driven combinationally.
  - When both handshakes occur on the same edge, the response retires and the new request is registered. The FSM goes straight to EXEC for a supported op, or stays in RESP with the error response for an unsupported one.
- `ALU_ISSUE_PIPE_EN` undefined: `req_ready` is 0 in RESP, and every response returns the FSM to IDLE.

## Test plan
- Reset, then request aluop=10, funct=0x20, a=5, b=7, tag=3, SETTLE=1 -> `alu_sel`=0010 held one cycle; response data=12, zero=0, err=0, tag=3 one edge after acceptance.
- aluop=01, a=b=0x1234 -> sel=0110, data=0, zero=1. Then aluop=10, funct=0x2A, a=2, b=9 -> data=1, zero=0.
- aluop=10, funct=0x1A (div) -> `rsp_valid` the edge after acceptance with err=1, data=0. `alu_sel`/`alu_op*` unchanged from the previous op.
- SETTLE=3, funct=0x18, a=6, b=7, `rsp_ready` low for 5 cycles -> data=42 captured at acceptance+3 and stable throughout the stall. `req_ready`=0 with the macro off. `rsp_valid` drops one edge after `rsp_ready` rises.
- `rst_n` pulsed low during EXEC -> all outputs at reset values immediately. No response appears afterwards, and the next request completes normally.
- With `ALU_ISSUE_PIPE_EN`, back-to-back ADD requests with `rsp_ready`=1 -> one response every SETTLE+1 cycles, tags in order, none lost.

Source files
------------

// File: rtl/alu_issue_ctrl_if.sv
// Request/response channel between the decode stage and the ALU issue controller.
// master = decode/consumer side, slave = controller side.
interface alu_issue_ctrl_if #(
    parameter int TAG_W = 4
);
    logic             req_valid;
    logic             req_ready;
    logic [1:0]       req_aluop;
    logic [5:0]       req_funct;
    logic [31:0]      req_a;
    logic [31:0]      req_b;
    logic [TAG_W-1:0] req_tag;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [31:0]      rsp_data;
    logic             rsp_zero;
    logic             rsp_err;
    logic [TAG_W-1:0] rsp_tag;

    modport master (
        output req_valid, req_aluop, req_funct, req_a, req_b, req_tag, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_zero, rsp_err, rsp_tag
    );

    modport slave (
        input  req_valid, req_aluop, req_funct, req_a, req_b, req_tag, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_zero, rsp_err, rsp_tag
    );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Issue controller wrapping the combinational ALU in a registered valid/ready request/response channel.
// Optional macro ALU_ISSUE_PIPE_EN: accept a new request on the same edge a response retires.
module alu_issue_ctrl #(
    parameter int TAG_W  = 4,
    parameter int SETTLE = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    alu_issue_ctrl_if.slave   ifc,
    output logic [31:0]       alu_op1,
    output logic [31:0]       alu_op2,
    output logic [3:0]        alu_sel,
    input  logic [31:0]       alu_out,
    input  logic              alu_zf,
    output logic              busy
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_RESP = 2'b10
    } state_t;

    localparam logic [3:0] SEL_AND   = 4'b0000;
    localparam logic [3:0] SEL_OR    = 4'b0001;
    localparam logic [3:0] SEL_ADD   = 4'b0010;
    localparam logic [3:0] SEL_MUL   = 4'b0101;
    localparam logic [3:0] SEL_SUB   = 4'b0110;
    localparam logic [3:0] SEL_SLT   = 4'b0111;
    localparam logic [3:0] SETTLE_M1 = 4'(SETTLE - 1);

    // Returns {supported, select}; division and anything unlisted are rejected.
    function automatic logic [4:0] decode_op(input logic [1:0] aluop, input logic [5:0] funct);
        logic [4:0] d;
        d = {1'b0, SEL_ADD};
        case (aluop)
            2'b00: d = {1'b1, SEL_ADD};
            2'b01: d = {1'b1, SEL_SUB};
            2'b10: begin
                case (funct)
                    6'h20:   d = {1'b1, SEL_ADD};
                    6'h22:   d = {1'b1, SEL_SUB};
                    6'h24:   d = {1'b1, SEL_AND};
                    6'h25:   d = {1'b1, SEL_OR};
                    6'h2A:   d = {1'b1, SEL_SLT};
                    6'h18:   d = {1'b1, SEL_MUL};
                    default: d = {1'b0, SEL_ADD};
                endcase
            end
            default: d = {1'b0, SEL_ADD};
        endcase
        return d;
    endfunction

    state_t           state_r;
    logic [3:0]       cnt_r;
    logic             ready_r;
    logic             busy_r;
    logic [31:0]      alu_op1_r;
    logic [31:0]      alu_op2_r;
    logic [3:0]       alu_sel_r;
    logic [TAG_W-1:0] tag_r;
    logic             rsp_valid_r;
    logic [31:0]      rsp_data_r;
    logic             rsp_zero_r;
    logic             rsp_err_r;
    logic [TAG_W-1:0] rsp_tag_r;

    logic [4:0]       dec_s;
    logic             dec_ok_s;
    logic [3:0]       dec_sel_s;
    logic             req_ready_s;
    logic             take_s;

    // Decode the incoming request and form the accept handshake.
    always_comb begin
        dec_s     = decode_op(ifc.req_aluop, ifc.req_funct);
        dec_ok_s  = dec_s[4];
        dec_sel_s = dec_s[3:0];
`ifdef ALU_ISSUE_PIPE_EN
        if (state_r == ST_RESP) begin
            req_ready_s = ifc.rsp_ready;
        end else begin
            req_ready_s = ready_r;
        end
`else
        req_ready_s = ready_r;
`endif
        take_s = ifc.req_valid & req_ready_s;
    end

    // Issue FSM: operand/select registers, settle counter and response register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            cnt_r       <= 4'd0;
            ready_r     <= 1'b1;
            busy_r      <= 1'b0;
            alu_op1_r   <= 32'd0;
            alu_op2_r   <= 32'd0;
            alu_sel_r   <= SEL_ADD;
            tag_r       <= '0;
            rsp_valid_r <= 1'b0;
            rsp_data_r  <= 32'd0;
            rsp_zero_r  <= 1'b0;
            rsp_err_r   <= 1'b0;
            rsp_tag_r   <= '0;
        end else begin
            case (state_r)
                ST_IDLE, ST_RESP: begin
                    if ((state_r == ST_RESP) && ifc.rsp_ready) begin
                        state_r     <= ST_IDLE;
                        rsp_valid_r <= 1'b0;
                        ready_r     <= 1'b1;
                        busy_r      <= 1'b0;
                    end
                    // A new request overrides the retire above when both land on one edge.
                    if (take_s) begin
                        ready_r <= 1'b0;
                        busy_r  <= 1'b1;
                        if (dec_ok_s) begin
                            alu_op1_r   <= ifc.req_a;
                            alu_op2_r   <= ifc.req_b;
                            alu_sel_r   <= dec_sel_s;
                            tag_r       <= ifc.req_tag;
                            cnt_r       <= SETTLE_M1;
                            rsp_valid_r <= 1'b0;
                            state_r     <= ST_EXEC;
                        end else begin
                            rsp_data_r  <= 32'd0;
                            rsp_zero_r  <= 1'b0;
                            rsp_err_r   <= 1'b1;
                            rsp_tag_r   <= ifc.req_tag;
                            rsp_valid_r <= 1'b1;
                            state_r     <= ST_RESP;
                        end
                    end
                end
                ST_EXEC: begin
                    if (cnt_r == 4'd0) begin
                        rsp_data_r  <= alu_out;
                        rsp_zero_r  <= alu_zf;
                        rsp_err_r   <= 1'b0;
                        rsp_tag_r   <= tag_r;
                        rsp_valid_r <= 1'b1;
                        state_r     <= ST_RESP;
                    end else begin
                        cnt_r <= cnt_r - 4'd1;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    ready_r     <= 1'b1;
                    busy_r      <= 1'b0;
                    rsp_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign ifc.req_ready = req_ready_s;
    assign ifc.rsp_valid = rsp_valid_r;
    assign ifc.rsp_data  = rsp_data_r;
    assign ifc.rsp_zero  = rsp_zero_r;
    assign ifc.rsp_err   = rsp_err_r;
    assign ifc.rsp_tag   = rsp_tag_r;
    assign alu_op1       = alu_op1_r;
    assign alu_op2       = alu_op2_r;
    assign alu_sel       = alu_sel_r;
    assign busy          = busy_r;
endmodule
